// File: rtl/addr_partition_pipe.sv
// addr_partition_pipe: splits trace reference addresses into byte-select,
// set index and tag. Results go into a 2-entry output queue so the LLC lookup
// stage can stall without losing references. The block also flags same-line
// re-references and counts accepted references.
// Optional build macro ADDR_PARTITION_INDEX_HASH_EN: out_index becomes the raw
// index XORed with the tag folded down to INDEX_W bits. same_line always
// compares the raw index.
module addr_partition_pipe #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned NUM_SETS   = 16384,
  parameter int unsigned CMD_W      = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  input  logic [ADDR_W-1:0]                                    in_addr,
  input  logic [CMD_W-1:0]                                     in_cmd,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [$clog2(LINE_BYTES)-1:0]                        out_byte_select,
  output logic [$clog2(NUM_SETS)-1:0]                          out_index,
  output logic [ADDR_W-$clog2(LINE_BYTES)-$clog2(NUM_SETS)-1:0] out_tag,
  output logic [CMD_W-1:0]                                     out_cmd,
  output logic                                                 out_same_line,
  output logic [31:0]                                          req_count
);

  localparam int unsigned OFFSET_W = $clog2(LINE_BYTES);
  localparam int unsigned INDEX_W  = $clog2(NUM_SETS);
  localparam int unsigned TAG_W    = ADDR_W - OFFSET_W - INDEX_W;

  // The address must leave at least one tag bit
  if (ADDR_W <= OFFSET_W + INDEX_W) begin : g_bad_tag_w
    $error("addr_partition_pipe: TAG_W must be at least 1");
  end

  typedef struct packed {
    logic [OFFSET_W-1:0] byte_select;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic [CMD_W-1:0]    cmd;
    logic                same_line;
  } entry_t;

  entry_t             mem [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         occ;
  logic [TAG_W-1:0]   last_tag;
  logic [INDEX_W-1:0] last_index;
  logic               last_vld;

  logic               accept;
  logic               pop;
  logic [INDEX_W-1:0] raw_index;
  logic [TAG_W-1:0]   dec_tag;
  entry_t             in_entry;
  entry_t             head;

`ifdef ADDR_PARTITION_INDEX_HASH_EN
  // XOR successive INDEX_W-bit slices of the tag; a short tag is zero-extended
  function automatic logic [INDEX_W-1:0] fold_tag(input logic [TAG_W-1:0] t);
    logic [INDEX_W-1:0] f;
    f = '0;
    for (int s = 0; s < int'(TAG_W); s += int'(INDEX_W)) begin
      f = f ^ INDEX_W'(t >> s);
    end
    return f;
  endfunction
`endif

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Input-side decode of the offered reference
  always_comb begin
    raw_index            = in_addr[OFFSET_W +: INDEX_W];
    dec_tag              = in_addr[OFFSET_W + INDEX_W +: TAG_W];
    in_entry             = '0;
    in_entry.byte_select = in_addr[OFFSET_W-1:0];
`ifdef ADDR_PARTITION_INDEX_HASH_EN
    in_entry.index       = raw_index ^ fold_tag(dec_tag);
`else
    in_entry.index       = raw_index;
`endif
    in_entry.tag         = dec_tag;
    in_entry.cmd         = in_cmd;
    in_entry.same_line   = last_vld && (dec_tag == last_tag) && (raw_index == last_index);
  end

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (accept && !pop) begin
        occ <= occ + 2'd1;
      end else if (!accept && pop) begin
        occ <= occ - 2'd1;
      end
    end
  end

  // Last accepted line and accepted-reference counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_tag   <= '0;
      last_index <= '0;
      last_vld   <= 1'b0;
      req_count  <= 32'd0;
    end else if (accept) begin
      last_tag   <= dec_tag;
      last_index <= raw_index;
      last_vld   <= 1'b1;
      req_count  <= req_count + 32'd1;
    end
  end

  // Outputs always present the head entry
  always_comb begin
    head            = mem[rd_ptr];
    out_byte_select = head.byte_select;
    out_index       = head.index;
    out_tag         = head.tag;
    out_cmd         = head.cmd;
    out_same_line   = head.same_line;
  end

  // Head must hold while the consumer stalls
  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> ($stable(head) && out_valid));

  // Occupancy never exceeds the queue depth
  a_occ_max: assert property (@(posedge clk) disable iff (!rst_n) occ <= 2'd2);

endmodule
